// File: rtl/shift_reg.sv
// Fixed-latency delay line: d appears on q after N enabled clock edges.
// N=0 is a plain wire. N>=1 uses a chain of enable-gated flops with synchronous reset.
module shift_reg #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_wire
      // Clock, reset and enable are intentionally inert at zero latency.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ clk_en;
      assign q = d;
    end else begin : g_stages
      logic [W-1:0] s_q [N];
      logic [W-1:0] s_d [N];

      always_comb begin
        s_d[0] = d;
        for (int i = 1; i < N; i++) begin
          s_d[i] = s_q[i-1];
        end
      end

      // Reset takes priority over the enable.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            s_q[i] <= '0;
          end
        end else if (clk_en) begin
          for (int i = 0; i < N; i++) begin
            s_q[i] <= s_d[i];
          end
        end
      end

      assign q = s_q[N-1];
    end
  endgenerate

endmodule

// File: tb/tb_shift_reg.sv
// Bench for shift_reg at (W=8,N=3), (W=32,N=0) and (W=1,N=1).
// Expectations come from per-instance histories of accepted words; a negedge monitor pops and compares.
module tb_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=8, N=3
  logic       rst3 = 1'b0, en3 = 1'b0;
  logic [7:0] d3 = '0, q3;
  // W=32, N=0
  logic        rst0 = 1'b0, en0 = 1'b0;
  logic [31:0] d0 = '0, q0;
  // W=1, N=1
  logic rst1 = 1'b0, en1 = 1'b0;
  logic d1 = 1'b0, q1;

  shift_reg #(.W(8), .N(3)) u3 (.clk(clk), .rst(rst3), .clk_en(en3), .d(d3), .q(q3));
  shift_reg #(.W(32), .N(0)) u0 (.clk(clk), .rst(rst0), .clk_en(en0), .d(d0), .q(q0));
  shift_reg #(.W(1), .N(1)) u1 (.clk(clk), .rst(rst1), .clk_en(en1), .d(d1), .q(q1));

  int checks = 0;
  int errors = 0;

  // Words accepted since the last reset, oldest first.
  logic [7:0] acc3[$];
  logic       acc1[$];

  logic [7:0]  exp3[$];
  logic [31:0] exp0[$];
  logic        exp1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp3.size() > 0) chk("q_n3", {24'b0, q3}, {24'b0, exp3.pop_front()});
    if (exp0.size() > 0) chk("q_n0", q0, exp0.pop_front());
    if (exp1.size() > 0) chk("q_n1", {31'b0, q1}, {31'b0, exp1.pop_front()});
  end

  // One clock edge: update the reference histories from the inputs that edge sampled,
  // then push the q value each instance must show until the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst3) acc3.delete();
    else if (en3) acc3.push_back(d3);
    exp3.push_back(acc3.size() >= 3 ? acc3[acc3.size()-3] : 8'h00);

    if (rst1) acc1.delete();
    else if (en1) acc1.push_back(d1);
    exp1.push_back(acc1.size() >= 1 ? acc1[acc1.size()-1] : 1'b0);

    // Zero-latency instance: fresh word with random rst/clk_en, q must follow d immediately.
    d0   = $urandom;
    rst0 = 1'($urandom_range(0, 1));
    en0  = 1'($urandom_range(0, 1));
    exp0.push_back(d0);
  endtask

  // Directed driving: the 1-bit instance shares control and sees a pulse on words 4 and 6.
  task automatic drv(input logic r, input logic e, input logic [7:0] v);
    rst3 = r;
    en3  = e;
    d3   = v;
    rst1 = r;
    en1  = e;
    d1   = (v == 8'd4) || (v == 8'd6);
    tick();
  endtask

  initial begin
    d0 = 32'hDEADBEEF;
    // Reset for two cycles with enable high: reset must win.
    drv(1'b1, 1'b1, 8'hAA);
    drv(1'b1, 1'b1, 8'hAA);
    // Enable low: q must stay 0.
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 8'hAA);
    // Consecutive words for latency.
    for (int i = 1; i <= 8; i++) drv(1'b0, 1'b1, 8'(i));
    // Enable stall between 6 and 7.
    drv(1'b0, 1'b1, 8'd5);
    drv(1'b0, 1'b1, 8'd6);
    drv(1'b0, 1'b0, 8'hEE);
    drv(1'b0, 1'b0, 8'hDD);
    drv(1'b0, 1'b1, 8'd7);
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 8'h00);
    // Reset with three words in flight.
    drv(1'b0, 1'b1, 8'd9);
    drv(1'b0, 1'b1, 8'd10);
    drv(1'b0, 1'b1, 8'd11);
    drv(1'b1, 1'b1, 8'd12);
    for (int i = 13; i < 19; i++) drv(1'b0, 1'b1, 8'(i));
    // Randomized traffic, independent per instance.
    for (int i = 0; i < 400; i++) begin
      rst3 = ($urandom_range(0, 49) == 0);
      en3  = ($urandom_range(0, 3) != 0);
      d3   = 8'($urandom);
      rst1 = ($urandom_range(0, 49) == 0);
      en1  = ($urandom_range(0, 3) != 0);
      d1   = 1'($urandom);
      tick();
    end
    repeat (3) @(negedge clk);
    #1;
    if (exp3.size() != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d/%0d expectations left, required 0", exp3.size(), exp0.size(), exp1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
